totient_seg_checker: RTL
========================

Name: totient_seg_checker

Overview:
- Receive-side monitor for the Euler-totient seven-segment display stream.
- Samples the ABCDEFG segment lines, decodes each sample back to a 4-bit hex digit, and tracks the forward/reverse ping-pong sequence phi(1..16).
- Flags each sample that does not match the expected totient value.
- Sits beside the totient display generator on the same clk_0/R domain; used as an on-chip self-check and as a bench scoreboard.

Parameters:
- SEG_ACTIVE_LOW, 0, 1 = inputs are active-low (common anode); they are inverted before decode.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk_0  in  1  system clock, rising-edge.
- R  in  1  reset, synchronous, active-high.
- sample_en  in  1  qualifies seg_in for the current cycle (one display step).
- seg_in  in  7  segments {A,B,C,D,E,F,G}; A = bit 6 (top), G = bit 0 (middle).
- digit  out  4  decoded hex value of the last sample.
- digit_valid  out  1  one-cycle pulse, one cycle after each sample_en.
- seg_invalid  out  1  last sample is not one of the 16 legal glyphs; valid with digit_valid.
- exp_digit  out  4  expected value for the last sample.
- mismatch  out  1  pulse with digit_valid when digit != exp_digit or seg_invalid.
- index  out  5  sequence position n (1..16) of the next expected sample.
- dir  out  1  1 = forward (n increasing), 0 = reverse.
- pass_done  out  1  one-cycle pulse when an endpoint dwell sample is consumed.
- err_count  out  ERR_W  saturating count of mismatches since reset.

Behaviour:
- All state updates on the rising edge of clk_0.
- R is sampled synchronously and overrides sample_en in the same cycle.
- Reset values:
  - digit = 0, exp_digit = 0.
  - digit_valid, seg_invalid, mismatch, pass_done = 0.
  - err_count = 0.
  - index = 1, dir = 1, state = FWD.
- Decode:
  - Polarity correction first, then a combinational lookup.
  - Legal glyphs (ABCDEFG):
    - 0=1111110, 1=0110000, 2=1101101, 3=1111001
    - 4=0110011, 5=1011011, 6=1011111, 7=1110000
    - 8=1111111, 9=1111011, A=1110111, b=0011111
    - C=1001110, d=0111101, E=1001111, F=1000111
  - Any other pattern: digit = 0, seg_invalid = 1.
- Expected table: phi(1..16) = 1,1,2,2,4,2,6,4,6,4,A,4,C,6,8,8.
- Latency: sample on edge k (sample_en = 1) produces digit, exp_digit, digit_valid, mismatch and pass_done on edge k+1. Outputs hold until the next sample, except the pulses, which last one cycle.
- State machine (advances only on sample_en):
  - FWD: compare against phi(index). If index < 16, index++. If index = 16, go to TOP (index stays 16).
  - TOP: dwell sample compared against phi(16). Then pass_done = 1, dir = 0, index = 15, go to REV.
  - REV: compare against phi(index). If index > 1, index--. If index = 1, go to BOT (index stays 1).
  - BOT: dwell sample compared against phi(1). Then pass_done = 1, dir = 1, index = 2, go to FWD.
- Resulting expected stream from reset: 1,1,2,2,4,2,6,4,6,4,A,4,C,6,8,8,8,8,6,C,4,A,4,6,4,6,2,4,2,2,1,1,1,1,2,...
- Mismatch does not stall or resync the tracker; the sequence advances in lockstep regardless.
- err_count increments on each mismatch and saturates at 2^ERR_W-1.
- sample_en = 0: no state change; pulse outputs drop to 0.
- R asserted mid-sequence: all of the above return to reset values on that edge; the sample presented in that cycle is discarded.
- Back-to-back sample_en every cycle is supported (throughput 1 sample/cycle).

Decomposition:
- Shared package totient_pkg holds:
  - The 16 segment glyph constants.
  - The phi table (16 x 4-bit constant array).
  - State encoding FWD/TOP/REV/BOT.
- Natural sub-module: seg7_to_hex (combinational 7-to-4 decode plus invalid flag, polarity parameter). Reusable by other display logic.
- The top holds the FSM, index/dir registers, output registers and the counter.

Test Plan:
- Reset, then 16 samples of the correct glyphs for 1,1,2,2,4,2,6,4,6,4,A,4,C,6,8,8 -> mismatch never 1, err_count = 0, index = 16, state TOP after the 16th.
- Continue with 8 (dwell), then reverse 8,6,C,4,A,4,6,4,6,2,4,2,2,1,1, then 1 (dwell) -> pass_done pulses exactly after each dwell sample; dir goes 0 then 1; err_count = 0.
- Inject glyph 0110011 (4) at sample 3, where 2 is expected -> digit = 4, exp_digit = 2, mismatch pulse, err_count = 1, index still advances to 4.
- Present seg_in = 0000001 -> seg_invalid = 1, digit = 0, mismatch = 1.
- sample_en low for 5 cycles mid-stream -> index, dir and err_count unchanged; digit_valid stays 0.
- Assert R for 1 cycle at index 9 while sample_en = 1 -> next cycle index = 1, dir = 1, err_count = 0, no digit_valid. Repeat the first scenario with SEG_ACTIVE_LOW = 1 and inverted glyphs -> zero mismatches.

Source files
------------

// File: rtl/totient_pkg.sv
// Shared constants for the totient seven-segment stream: glyphs, phi table, tracker states.
package totient_pkg;

    // Segment glyphs, bit order {A,B,C,D,E,F,G}, active-high
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    // phi(n) for n = 1..16, stored at position n-1
    localparam logic [3:0] PHI_TABLE [16] = '{
        4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h2, 4'h6, 4'h4,
        4'h6, 4'h4, 4'hA, 4'h4, 4'hC, 4'h6, 4'h8, 4'h8
    };

    // Sequence position 1..16 sits one above the table slot
    localparam logic [4:0] IDX_FIRST = 5'd1;
    localparam logic [4:0] IDX_LAST  = 5'd16;

    typedef enum logic [1:0] {
        FWD = 2'd0,
        TOP = 2'd1,
        REV = 2'd2,
        BOT = 2'd3
    } state_t;

    // Expected digit for sequence position n (1..16)
    function automatic logic [3:0] phi_of(input logic [4:0] n);
        return PHI_TABLE[4'(n - 5'd1)];
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment to hex decoder with illegal-glyph flag.
module seg7_to_hex
    import totient_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       invalid
);

    logic [6:0] seg_fix;

    // Common-anode displays drive a lit segment low, so flip to active-high first
    assign seg_fix = SEG_ACTIVE_LOW ? ~seg : seg;

    // Map each legal glyph back to its value; anything else decodes as 0 and is flagged
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        hex     = 4'h0;
        invalid = 1'b0;
        case (seg_fix)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/totient_seg_checker.sv
// Receive-side checker: decodes each segment sample and compares it with the
// phi(1..16) forward/reverse ping-pong sequence, counting mismatches.
module totient_seg_checker
    import totient_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter int ERR_W          = 8
) (
    input  logic             clk_0,
    input  logic             R,
    input  logic             sample_en,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             seg_invalid,
    output logic [3:0]       exp_digit,
    output logic             mismatch,
    output logic [4:0]       index,
    output logic             dir,
    output logic             pass_done,
    output logic [ERR_W-1:0] err_count
);

    state_t     state, state_nx;
    logic [4:0] index_nx;
    logic       dir_nx;
    logic       pass_nx;
    logic [3:0] dec_hex;
    logic       dec_invalid;
    logic [3:0] exp_now;
    logic       mismatch_nx;

    seg7_to_hex #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dec (
        .seg     (seg_in),
        .hex     (dec_hex),
        .invalid (dec_invalid)
    );

    // Expected value always comes from the current position; TOP/BOT hold 16/1
    assign exp_now     = phi_of(index);
    assign mismatch_nx = sample_en && (dec_invalid || (dec_hex != exp_now));

    // Tracker next-state: walk up, dwell at 16, walk down, dwell at 1
    always_comb begin
        state_nx = state;
        index_nx = index;
        dir_nx   = dir;
        pass_nx  = 1'b0;
        if (sample_en) begin
            case (state)
                FWD: begin
                    if (index == IDX_LAST) state_nx = TOP;
                    else                   index_nx = index + 5'd1;
                end
                TOP: begin
                    pass_nx  = 1'b1;
                    dir_nx   = 1'b0;
                    index_nx = IDX_LAST - 5'd1;
                    state_nx = REV;
                end
                REV: begin
                    if (index == IDX_FIRST) state_nx = BOT;
                    else                    index_nx = index - 5'd1;
                end
                BOT: begin
                    pass_nx  = 1'b1;
                    dir_nx   = 1'b1;
                    index_nx = IDX_FIRST + 5'd1;
                    state_nx = FWD;
                end
                default: state_nx = FWD;
            endcase
        end
    end

    // Tracker state register; reset wins over a sample presented in the same cycle
    always_ff @(posedge clk_0) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values, independent of statement order.
        if (R) begin
            state <= FWD;
            index <= IDX_FIRST;
            dir   <= 1'b1;
        end else begin
            state <= state_nx;
            index <= index_nx;
            dir   <= dir_nx;
        end
    end

    // Result registers: values hold between samples, pulses last one cycle
    always_ff @(posedge clk_0) begin
        if (R) begin
            digit       <= 4'h0;
            exp_digit   <= 4'h0;
            seg_invalid <= 1'b0;
            digit_valid <= 1'b0;
            mismatch    <= 1'b0;
            pass_done   <= 1'b0;
        end else begin
            digit_valid <= sample_en;
            mismatch    <= mismatch_nx;
            pass_done   <= pass_nx;
            if (sample_en) begin
                digit       <= dec_hex;
                exp_digit   <= exp_now;
                seg_invalid <= dec_invalid;
            end
        end
    end

    // Saturating mismatch counter
    always_ff @(posedge clk_0) begin
        if (R)                                   err_count <= '0;
        else if (mismatch_nx && err_count != '1) err_count <= err_count + ERR_W'(1);
    end

endmodule
